// File: rtl/uart_defs.sv
// Shared types for the UART packet parser: FSM states, drop causes and the
// checksum rule.
package uart_defs;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } PktState_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } PktErr_t;

    // A frame is good when LEN + payload + CSUM wraps to zero modulo 256.
    function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
        logic [7:0] total;
        total = sum + csum;
        return (total == 8'd0);
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: DEPTH x 8 flops, one synchronous write port and one
// combinational read port. Contents are not reset.
module uart_pkt_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_pkt_parser.sv
// Frame parser for SOF, LEN, payload, CSUM byte streams. Valid frames are
// buffered and replayed on the out side; bad frames are dropped with a cause.
module uart_pkt_parser
    import uart_defs::*;
#(
    parameter logic [7:0] SOF     = 8'h7E,
    parameter int         MAX_LEN = 64,
    parameter int         TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_ok,
    output logic       pkt_error,
    output logic [1:0] err_code,
    output logic [2:0] dbg_state
);

    // Handshakes on both sides transfer a byte on a rising edge where
    // valid and ready are both high; valid never waits on ready.

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    PktState_t     r_state;
    PktErr_t       r_err;
    logic [7:0]    r_len;
    logic [7:0]    r_wr;
    logic [7:0]    r_rd;
    logic [7:0]    r_sum;
    logic [TW-1:0] r_idle;
    logic          r_pkt_ok;
    logic          r_pkt_err;

    logic          w_accept;
    logic          w_counting;
    logic          w_timeout;
    logic          w_last;
    logic          w_we;
    logic [7:0]    w_rdata;

    assign w_accept   = in_valid && in_ready;
    assign w_counting = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
    assign w_timeout  = (TIMEOUT != 0) && w_counting && (r_idle == TIMEOUT_C);
    assign w_last     = (r_rd == r_len - 8'd1);
    assign w_we       = w_accept && (r_state == ST_PAYLOAD) && !w_timeout;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_err     <= ERR_NONE;
            r_len     <= 8'd0;
            r_wr      <= 8'd0;
            r_rd      <= 8'd0;
            r_sum     <= 8'd0;
            r_idle    <= '0;
            r_pkt_ok  <= 1'b0;
            r_pkt_err <= 1'b0;
        end else begin
            r_pkt_ok  <= 1'b0;
            r_pkt_err <= 1'b0;

            if (w_accept || !w_counting || TIMEOUT == 0) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + TW'(1);
            end

            // A timeout wins over a byte arriving in the same cycle.
            if (w_timeout) begin
                r_pkt_err <= 1'b1;
                r_err     <= ERR_TIMEOUT;
                r_idle    <= '0;
                r_state   <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept && in_data == SOF) begin
                            r_state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (w_accept) begin
                            if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
                                r_pkt_err <= 1'b1;
                                r_err     <= ERR_LEN;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_len   <= in_data;
                                r_sum   <= in_data;
                                r_wr    <= 8'd0;
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (w_accept) begin
                            r_sum <= r_sum + in_data;
                            r_wr  <= r_wr + 8'd1;
                            if (r_wr == r_len - 8'd1) begin
                                r_state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (w_accept) begin
                            if (csum_ok(r_sum, in_data)) begin
                                r_pkt_ok <= 1'b1;
                                r_rd     <= 8'd0;
                                r_state  <= ST_DRAIN;
                            end else begin
                                r_pkt_err <= 1'b1;
                                r_err     <= ERR_CSUM;
                                r_state   <= ST_IDLE;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (out_ready) begin
                            r_rd <= r_rd + 8'd1;
                            if (w_last) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_ready  = (r_state != ST_DRAIN);
    assign out_valid = (r_state == ST_DRAIN);
    assign out_last  = out_valid && w_last;
    assign out_data  = w_rdata;
    assign pkt_ok    = r_pkt_ok;
    assign pkt_error = r_pkt_err;
    assign err_code  = r_err;
    assign dbg_state = r_state;

endmodule
